// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU operations,
// sequencer states and instruction classes.
package cpu_pkg;

    localparam int unsigned OP_FIELD_W = 5;

    localparam logic [OP_FIELD_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_FIELD_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_FIELD_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_FIELD_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_FIELD_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_FIELD_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_FIELD_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_FIELD_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_FIELD_W-1:0] OP_SHL  = 5'b01000;
    localparam logic [OP_FIELD_W-1:0] OP_ROR  = 5'b01001;
    localparam logic [OP_FIELD_W-1:0] OP_ROL  = 5'b01010;
    localparam logic [OP_FIELD_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_FIELD_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_FIELD_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_FIELD_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OP_FIELD_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_FIELD_W-1:0] OP_HALT = 5'b11011;

    // ALU operation codes share the encoding of the matching R-type opcode.
    localparam logic [OP_FIELD_W-1:0] ALU_NONE = 5'b00000;
    localparam logic [OP_FIELD_W-1:0] ALU_ADD  = OP_ADD;
    localparam logic [OP_FIELD_W-1:0] ALU_AND  = OP_AND;
    localparam logic [OP_FIELD_W-1:0] ALU_OR   = OP_OR;

    typedef enum logic [3:0] {
        S_RESET,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_IMM,
        CLS_LD,
        CLS_LDI,
        CLS_ST,
        CLS_BR,
        CLS_NOP,
        CLS_HALT
    } cls_t;

    function automatic logic [3:0] t_index(input state_t s);
        logic [3:0] idx;
        case (s)
            S_T0:    idx = 4'd0;
            S_T1:    idx = 4'd1;
            S_T2:    idx = 4'd2;
            S_T3:    idx = 4'd3;
            S_T4:    idx = 4'd4;
            S_T5:    idx = 4'd5;
            S_T6:    idx = 4'd6;
            S_T7:    idx = 4'd7;
            default: idx = 4'd0;
        endcase
        return idx;
    endfunction

    function automatic logic is_running(input state_t s);
        return (s != S_RESET) && (s != S_HALT);
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode decoder: instruction class plus the ALU operation used
// by the immediate forms.
module instr_class_decode
    import cpu_pkg::*;
#(
    parameter int unsigned OPW = 5
) (
    input  logic [OP_FIELD_W-1:0] op,
    output cls_t                  cls,
    output logic [OPW-1:0]        imm_alu_op
);

    always_comb begin
        cls        = CLS_NOP;
        imm_alu_op = OPW'(ALU_NONE);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_ALU;
            OP_ADDI: begin
                cls        = CLS_IMM;
                imm_alu_op = OPW'(ALU_ADD);
            end
            OP_ANDI: begin
                cls        = CLS_IMM;
                imm_alu_op = OPW'(ALU_AND);
            end
            OP_ORI: begin
                cls        = CLS_IMM;
                imm_alu_op = OPW'(ALU_OR);
            end
            OP_LD:   cls = CLS_LD;
            OP_LDI:  cls = CLS_LDI;
            OP_ST:   cls = CLS_ST;
            OP_BR:   cls = CLS_BR;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state sequencer driving every datapath strobe; Moore outputs
// decoded from the registered state and the IR opcode field.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned DW  = 32,
    parameter int unsigned OPW = 5
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [DW-1:0]  ir,
    input  logic           con_ff,
    output logic           PCout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           Cout,
    output logic           BAout,
    output logic           Rout,
    output logic           PCin,
    output logic           IncPC,
    output logic           MARin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           Zin,
    output logic           Rin,
    output logic           CONin,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Read,
    output logic           Write,
    output logic [OPW-1:0] opcode,
    output logic           run,
    output logic [3:0]     step
);

    state_t                state;
    state_t                state_next;
    cls_t                  cls;
    logic [OPW-1:0]        imm_op;
    logic [OP_FIELD_W-1:0] ir_op;
    logic                  unused_ir;

    assign ir_op = ir[31:27];
    // Register fields are selected inside the datapath via Gra/Grb/Grc.
    assign unused_ir = ^ir;

    instr_class_decode #(
        .OPW (OPW)
    ) u_decode (
        .op         (ir_op),
        .cls        (cls),
        .imm_alu_op (imm_op)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RESET: state_next = S_T0;
            S_T0:    state_next = S_T1;
            S_T1:    state_next = S_T2;
            S_T2:    state_next = S_T3;
            S_T3: begin
                if (cls == CLS_HALT) begin
                    state_next = S_HALT;
                end else if (cls == CLS_NOP) begin
                    state_next = S_T0;
                end else begin
                    state_next = S_T4;
                end
            end
            S_T4:    state_next = S_T5;
            S_T5: begin
                if (cls == CLS_LD || cls == CLS_ST || cls == CLS_BR) begin
                    state_next = S_T6;
                end else begin
                    state_next = S_T0;
                end
            end
            S_T6: begin
                if (cls == CLS_LD || cls == CLS_ST) begin
                    state_next = S_T7;
                end else begin
                    state_next = S_T0;
                end
            end
            S_T7:    state_next = S_T0;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        Cout    = 1'b0;
        BAout   = 1'b0;
        Rout    = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Rin     = 1'b0;
        CONin   = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        opcode  = '0;
        run     = is_running(state);
        step    = t_index(state);

        case (state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CLS_ALU, CLS_IMM: begin
                        Grb  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        Grb   = 1'b1;
                        BAout = 1'b1;
                        Yin   = 1'b1;
                    end
                    CLS_BR: begin
                        Gra   = 1'b1;
                        Rout  = 1'b1;
                        CONin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    CLS_ALU: begin
                        Grc    = 1'b1;
                        Rout   = 1'b1;
                        Zin    = 1'b1;
                        opcode = OPW'(ir_op);
                    end
                    CLS_IMM: begin
                        Cout   = 1'b1;
                        Zin    = 1'b1;
                        opcode = imm_op;
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        Cout   = 1'b1;
                        Zin    = 1'b1;
                        opcode = OPW'(ALU_ADD);
                    end
                    CLS_BR: begin
                        PCout = 1'b1;
                        Yin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    CLS_ALU, CLS_IMM, CLS_LDI: begin
                        Zlowout = 1'b1;
                        Gra     = 1'b1;
                        Rin     = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        Zlowout = 1'b1;
                        MARin   = 1'b1;
                    end
                    CLS_BR: begin
                        Cout   = 1'b1;
                        Zin    = 1'b1;
                        opcode = OPW'(ALU_ADD);
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    CLS_LD: begin
                        Read  = 1'b1;
                        MDRin = 1'b1;
                    end
                    CLS_ST: begin
                        Gra   = 1'b1;
                        Rout  = 1'b1;
                        MDRin = 1'b1;
                    end
                    CLS_BR: begin
                        Zlowout = 1'b1;
                        // Branch target is committed only when the condition holds.
                        PCin    = con_ff;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    CLS_LD: begin
                        MDRout = 1'b1;
                        Gra    = 1'b1;
                        Rin    = 1'b1;
                    end
                    CLS_ST:  Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: the stimulus thread queues the expected strobe vector for
// each cycle; a monitor pops and compares on the falling edge.
module tb_control_sequencer;

    logic        clk;
    logic        clr;
    logic [31:0] ir;
    logic        con_ff;
    logic        PCout, Zlowout, MDRout, Cout, BAout, Rout;
    logic        PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, Rin, CONin;
    logic        Gra, Grb, Grc, Read, Write;
    logic [4:0]  opcode;
    logic        run;
    logic [3:0]  step;

    control_sequencer #(
        .DW  (32),
        .OPW (5)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .ir      (ir),
        .con_ff  (con_ff),
        .PCout   (PCout),
        .Zlowout (Zlowout),
        .MDRout  (MDRout),
        .Cout    (Cout),
        .BAout   (BAout),
        .Rout    (Rout),
        .PCin    (PCin),
        .IncPC   (IncPC),
        .MARin   (MARin),
        .MDRin   (MDRin),
        .IRin    (IRin),
        .Yin     (Yin),
        .Zin     (Zin),
        .Rin     (Rin),
        .CONin   (CONin),
        .Gra     (Gra),
        .Grb     (Grb),
        .Grc     (Grc),
        .Read    (Read),
        .Write   (Write),
        .opcode  (opcode),
        .run     (run),
        .step    (step)
    );

    localparam logic [19:0] B_PCOUT = 20'h80000;
    localparam logic [19:0] B_ZLOW  = 20'h40000;
    localparam logic [19:0] B_MDRO  = 20'h20000;
    localparam logic [19:0] B_COUT  = 20'h10000;
    localparam logic [19:0] B_BAOUT = 20'h08000;
    localparam logic [19:0] B_ROUT  = 20'h04000;
    localparam logic [19:0] B_PCIN  = 20'h02000;
    localparam logic [19:0] B_INCPC = 20'h01000;
    localparam logic [19:0] B_MARIN = 20'h00800;
    localparam logic [19:0] B_MDRIN = 20'h00400;
    localparam logic [19:0] B_IRIN  = 20'h00200;
    localparam logic [19:0] B_YIN   = 20'h00100;
    localparam logic [19:0] B_ZIN   = 20'h00080;
    localparam logic [19:0] B_RIN   = 20'h00040;
    localparam logic [19:0] B_CONIN = 20'h00020;
    localparam logic [19:0] B_GRA   = 20'h00010;
    localparam logic [19:0] B_GRB   = 20'h00008;
    localparam logic [19:0] B_GRC   = 20'h00004;
    localparam logic [19:0] B_READ  = 20'h00002;
    localparam logic [19:0] B_WRITE = 20'h00001;

    typedef struct {
        string       name;
        logic [29:0] vec;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          fails  = 0;
    logic [29:0] act;

    assign act = {PCout, Zlowout, MDRout, Cout, BAout, Rout, PCin, IncPC, MARin, MDRin,
                  IRin, Yin, Zin, Rin, CONin, Gra, Grb, Grc, Read, Write, opcode, run, step};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] ev(input logic [19:0] s, input logic [4:0] op,
                                       input logic [3:0] t);
        return {s, op, 1'b1, t};
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (act !== e.vec) begin
                fails++;
                $display("FAIL %s: got %h expected %h (strobes|op|run|step)", e.name, act,
                         e.vec);
            end
        end
    end

    // Queue one cycle's expectation, then advance to just after the next edge.
    task automatic cyc(input string name, input logic [29:0] vec);
        sb.push_back('{name: name, vec: vec});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string name, input logic [31:0] irv);
        cyc({name, "_t0"}, ev(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 5'd0, 4'd0));
        cyc({name, "_t1"}, ev(B_ZLOW | B_PCIN | B_READ | B_MDRIN, 5'd0, 4'd1));
        ir = irv;
        cyc({name, "_t2"}, ev(B_MDRO | B_IRIN, 5'd0, 4'd2));
    endtask

    task automatic alu3(input string name, input logic [31:0] irv, input logic [19:0] t4s,
                        input logic [4:0] op, input logic [19:0] t3s);
        fetch(name, irv);
        cyc({name, "_t3"}, ev(t3s, 5'd0, 4'd3));
        cyc({name, "_t4"}, ev(t4s, op, 4'd4));
        cyc({name, "_t5"}, ev(B_ZLOW | B_GRA | B_RIN, 5'd0, 4'd5));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        clr    = 1'b1;
        ir     = 32'h0;
        con_ff = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 30'h0);
        clr = 1'b0;
        cyc("reset_release", 30'h0);
        cyc("first_t0", ev(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 5'd0, 4'd0));

        // Mid-T1 asynchronous clear held for 15 ns.
        #2;
        clr = 1'b1;
        #1;
        checks++;
        if (act !== 30'h0) begin
            fails++;
            $display("FAIL async_clr: got %h expected %h", act, 30'h0);
        end
        #14;
        clr = 1'b0;
        @(posedge clk);
        #1;

        alu3("and", 32'h28918000, B_GRC | B_ROUT | B_ZIN, 5'b00101, B_GRB | B_ROUT | B_YIN);

        fetch("ld", 32'h00800055);
        cyc("ld_t3", ev(B_GRB | B_BAOUT | B_YIN, 5'd0, 4'd3));
        cyc("ld_t4", ev(B_COUT | B_ZIN, 5'b00011, 4'd4));
        cyc("ld_t5", ev(B_ZLOW | B_MARIN, 5'd0, 4'd5));
        cyc("ld_t6", ev(B_READ | B_MDRIN, 5'd0, 4'd6));
        cyc("ld_t7", ev(B_MDRO | B_GRA | B_RIN, 5'd0, 4'd7));

        fetch("st", 32'h10800010);
        cyc("st_t3", ev(B_GRB | B_BAOUT | B_YIN, 5'd0, 4'd3));
        cyc("st_t4", ev(B_COUT | B_ZIN, 5'b00011, 4'd4));
        cyc("st_t5", ev(B_ZLOW | B_MARIN, 5'd0, 4'd5));
        cyc("st_t6", ev(B_GRA | B_ROUT | B_MDRIN, 5'd0, 4'd6));
        cyc("st_t7", ev(B_WRITE, 5'd0, 4'd7));

        for (int k = 0; k < 2; k++) begin
            con_ff = (k == 0);
            fetch(k == 0 ? "br_taken" : "br_not", 32'h98800004);
            cyc("br_t3", ev(B_GRA | B_ROUT | B_CONIN, 5'd0, 4'd3));
            cyc("br_t4", ev(B_PCOUT | B_YIN, 5'd0, 4'd4));
            cyc("br_t5", ev(B_COUT | B_ZIN, 5'b00011, 4'd5));
            cyc("br_t6", ev(k == 0 ? (B_ZLOW | B_PCIN) : B_ZLOW, 5'd0, 4'd6));
        end
        con_ff = 1'b0;

        alu3("addi", 32'h60000000, B_COUT | B_ZIN, 5'b00011, B_GRB | B_ROUT | B_YIN);
        alu3("andi", 32'h68000000, B_COUT | B_ZIN, 5'b00101, B_GRB | B_ROUT | B_YIN);
        alu3("ori", 32'h70000000, B_COUT | B_ZIN, 5'b00110, B_GRB | B_ROUT | B_YIN);
        alu3("ldi", 32'h08000000, B_COUT | B_ZIN, 5'b00011, B_GRB | B_BAOUT | B_YIN);
        alu3("shl", 32'h40000000, B_GRC | B_ROUT | B_ZIN, 5'b01000, B_GRB | B_ROUT | B_YIN);

        fetch("nop", 32'hD0000000);
        cyc("nop_t3", ev(20'h0, 5'd0, 4'd3));
        fetch("unlisted", 32'h78000000);
        cyc("unlisted_t3", ev(20'h0, 5'd0, 4'd3));

        fetch("halt", 32'hD8000000);
        cyc("halt_t3", ev(20'h0, 5'd0, 4'd3));
        for (int i = 0; i < 22; i++) cyc("halt_idle", 30'h0);

        clr = 1'b1;
        cyc("halt_clr", 30'h0);
        clr = 1'b0;
        cyc("halt_reset", 30'h0);
        cyc("post_halt_t0", ev(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 5'd0, 4'd0));

        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that sits directly upstream of `datapath`.
- Sequences the T-state timing per instruction and drives every datapath strobe: PC/MAR/MDR/IR/Y/Z/register-file enables, `Read`/`Write`, ALU opcode.
- Decodes the instruction held in the datapath IR (fed back as `ir`).
- Replaces hand-sequenced testbench stimulus with a free-running fetch/decode/execute loop.

Parameters:
- `DW`, 32, datapath/IR width
- `OPW`, 5, opcode / ALU-op field width

Ports:
- `clk`  in  1  system clock, rising-edge
- `clr`  in  1  reset; asynchronous, active-high
- `ir`  in  DW  current IR contents from datapath
- `con_ff`  in  1  branch-condition flag from datapath CON logic
- `PCout, Zlowout, MDRout, Cout, BAout, Rout`  out  1 each  bus-drive enables
- `PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, Rin, CONin`  out  1 each  load enables
- `Gra, Grb, Grc`  out  1 each  register-field select (`ir[26:23]` / `ir[22:19]` / `ir[18:15]`)
- `Read, Write`  out  1 each  memory strobes
- `opcode`  out  OPW  ALU operation to datapath
- `run`  out  1  high while executing; low in RESET and HALT
- `step`  out  4  current T index (0..7), debug

Behaviour:
- Moore machine. All outputs are a combinational decode of the registered state plus `ir[31:27]`. `ir` is stable from the cycle after T2 until the next T2.
- `clr`=1 forces state RESET immediately. In RESET every output is 0, including `opcode` = 0, `run` = 0 and `step` = 0.
- RESET -> T0 on the first rising edge after `clr` falls.
- `clr` mid-instruction abandons the instruction; no further strobes are issued.
- Fetch (all classes):
  - T0: `PCout`, `MARin`, `IncPC`, `Zin`
  - T1: `Zlowout`, `PCin`, `Read`, `MDRin`
  - T2: `MDRout`, `IRin`
- Class is taken from `ir[31:27]` at T3. One state per clock. The last T-state of each class returns to T0.
- ALU R-type (00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl, 01001 ror, 01010 rol):
  - T3: `Grb`, `Rout`, `Yin`
  - T4: `Grc`, `Rout`, `Zin`, `opcode` = `ir[31:27]`
  - T5: `Zlowout`, `Gra`, `Rin`
- Immediate (01100 addi, 01101 andi, 01110 ori):
  - T3: `Grb`, `Rout`, `Yin`
  - T4: `Cout`, `Zin`, `opcode` = 00011 / 00101 / 00110 respectively
  - T5: `Zlowout`, `Gra`, `Rin`
- `ldi` (00001):
  - T3: `Grb`, `BAout`, `Yin`
  - T4: `Cout`, `Zin`, `opcode` = 00011
  - T5: `Zlowout`, `Gra`, `Rin`
- `ld` (00000):
  - T3–T4 as `ldi`
  - T5: `Zlowout`, `MARin`
  - T6: `Read`, `MDRin`
  - T7: `MDRout`, `Gra`, `Rin`
- `st` (00010):
  - T3–T5 as `ld`
  - T6: `Gra`, `Rout`, `MDRin`
  - T7: `Write`
- `br` (10011):
  - T3: `Gra`, `Rout`, `CONin`
  - T4: `PCout`, `Yin`
  - T5: `Cout`, `Zin`, `opcode` = 00011
  - T6: `Zlowout`; `PCin` only if `con_ff`=1, sampled combinationally in T6
- `nop` (11010) and every unlisted opcode: T3 asserts nothing, then T0.
- `halt` (11011): T3 -> HALT. HALT is absorbing until `clr`; all outputs 0, `run` = 0, `step` = 0.
- `opcode` output = 0 in every state where `Zin` is not asserted for an ALU operation. T0 `Zin` uses `IncPC`, not `opcode`.
- `step` = T index; `run` = 1 in T0..T7.

Decomposition:
- `cpu_pkg` holds:
  - opcode localparams (OP_LD … OP_HALT)
  - state encoding (S_RESET, S_T0..S_T7, S_HALT)
  - instruction-class enum (CLS_ALU, CLS_IMM, CLS_LD, CLS_LDI, CLS_ST, CLS_BR, CLS_NOP, CLS_HALT)
  - ALU op constants
- One sub-module, `instr_class_decode`: pure combinational, opcode -> class plus immediate ALU-op mapping.
- The sequencer FSM and output decode stay in `control_sequencer`.

Test Plan:
- `clr` pulsed high for 15 ns mid-cycle -> all outputs 0 immediately, asynchronously. T0 one edge after release with `PCout`=`MARin`=`IncPC`=`Zin`=1, `step`=0.
- `ir` = 0x28918000 (and R1,R2,R3) after T2 -> T3 `Grb`/`Rout`/`Yin`; T4 `Grc`/`Rout`/`Zin`, `opcode` = 00101; T5 `Zlowout`/`Gra`/`Rin`; then T0. Six cycles total.
- `ir` = 0x00800055 (ld) -> T3–T7 as specified: `Read` high only in T1 and T6, `Rin` only in T7, then T0. Eight cycles total.
- `ir` = 0x10800010 (st) -> `Write` high exactly one cycle, in T7. `Read` never asserted after T1.
- `ir` = 0x98800004 (br): `con_ff`=1 -> `PCin`=1 in T6; repeat with `con_ff`=0 -> `PCin`=0 in T6, `Zlowout`=1 in both runs.
- `ir` = 0xD8000000 (halt) -> HALT after T3, `run` = 0 and all strobes 0 for 20+ cycles. Then `clr` pulse -> RESET, then T0.
